// File: rtl/mc_control.sv
// Multi-cycle MIPS control unit: Moore FSM sequencing the shared ALU, memory port
// and register file, plus PC enable generation and a retired-instruction counter.
module mc_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       op,
  input  logic [5:0]       funct,
  input  logic             zero,
  output logic             pcen,
  output logic             iord,
  output logic             memwrite,
  output logic             irwrite,
  output logic             regdst,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       pcsrc,
  output logic [2:0]       aluop,
  output logic [3:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXECUTE = 4'd6,
    ALUWB   = 4'd7,
    BEQEX   = 4'd8,
    ADDIEX  = 4'd9,
    ADDIWB  = 4'd10,
    JEX     = 4'd11
  } state_t;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] aluop;
  } ctrl_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     st;
  state_t     nxt;
  ctrl_t      ctl;
  logic [2:0] functop;
  logic       term;
  logic       opok;

  // Moore decode table; applied to the next state so the controls come straight
  // out of flops in the cycle the state becomes current.
  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:   begin c.irwrite = 1'b1; c.pcwrite = 1'b1; c.alusrcb = 2'b01; c.aluop = 3'b010; end
      DECODE:  begin c.alusrcb = 2'b11; c.aluop = 3'b010; end
      MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.aluop = 3'b010; end
      MEMRD:   c.iord = 1'b1;
      MEMWB:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
      MEMWR:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
      EXECUTE: c.alusrca = 1'b1;
      ALUWB:   begin c.regdst = 1'b1; c.regwrite = 1'b1; end
      BEQEX:   begin c.alusrca = 1'b1; c.aluop = 3'b110; c.pcsrc = 2'b01; c.branch = 1'b1; end
      ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; c.aluop = 3'b010; end
      ADDIWB:  c.regwrite = 1'b1;
      JEX:     begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    opok = (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
    term = (st == MEMWB) || (st == MEMWR) || (st == ALUWB) ||
           (st == BEQEX) || (st == ADDIWB) || (st == JEX);
  end

  always_comb begin
    nxt = FETCH;
    case (st)
      FETCH:   nxt = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_RTYPE:     nxt = EXECUTE;
          OP_BEQ:       nxt = BEQEX;
          OP_ADDI:      nxt = ADDIEX;
          OP_J:         nxt = JEX;
          default:      nxt = FETCH;
        endcase
      end
      MEMADR:  nxt = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:   nxt = MEMWB;
      EXECUTE: nxt = ALUWB;
      ADDIEX:  nxt = ADDIWB;
      default: nxt = FETCH;
    endcase
  end

  always_comb begin
    case (funct)
      6'b100000: functop = 3'b010;
      6'b100010: functop = 3'b110;
      6'b100100: functop = 3'b000;
      6'b100101: functop = 3'b001;
      6'b101010: functop = 3'b111;
      default:   functop = 3'b010;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st      <= FETCH;
      ctl     <= decode(FETCH);
      retired <= '0;
    end else begin
      st  <= nxt;
      ctl <= decode(nxt);
      if (term)
        retired <= retired + CNT_W'(1);
    end
  end

  // Write enables are forced off while reset is high so an abandoned instruction
  // cannot commit anything.
  always_comb begin
    pcen     = ~reset & (ctl.pcwrite | (ctl.branch & zero));
    memwrite = ~reset & ctl.memwrite;
    irwrite  = ~reset & ctl.irwrite;
    regwrite = ~reset & ctl.regwrite;
    iord     = ctl.iord;
    regdst   = ctl.regdst;
    memtoreg = ctl.memtoreg;
    alusrca  = ctl.alusrca;
    alusrcb  = ctl.alusrcb;
    pcsrc    = ctl.pcsrc;
    aluop    = (st == EXECUTE) ? functop : ctl.aluop;
    illegal  = ~reset & (st == DECODE) & ~opok;
    state    = st;
  end

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: the driver walks each instruction's state plan and
// queues the expected per-cycle outputs; a negedge monitor pops and compares.
module tb_mc_control;

  localparam int CW = 4;

  typedef struct packed {
    logic [3:0]    state;
    logic          pcen;
    logic          iord;
    logic          memwrite;
    logic          irwrite;
    logic          regdst;
    logic          memtoreg;
    logic          regwrite;
    logic          alusrca;
    logic [1:0]    alusrcb;
    logic [1:0]    pcsrc;
    logic [2:0]    aluop;
    logic          illegal;
    logic [CW-1:0] retired;
  } obs_t;

  logic          clk;
  logic          reset;
  logic [5:0]    op;
  logic [5:0]    funct;
  logic          zero;
  logic          pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, illegal;
  logic [1:0]    alusrcb, pcsrc;
  logic [2:0]    aluop;
  logic [3:0]    state;
  logic [CW-1:0] retired;

  obs_t          sb[$];
  int            checks = 0;
  int            failures = 0;
  bit            scoreActive = 0;
  logic [CW-1:0] retiredModel = '0;

  mc_control #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .iord(iord), .memwrite(memwrite), .irwrite(irwrite),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite),
    .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop),
    .state(state), .illegal(illegal), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit legalOp(input logic [5:0] o);
    return o inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
  endfunction

  function automatic bit isTerminal(input int s);
    return s inside {4, 5, 7, 8, 10, 11};
  endfunction

  // Expected outputs for one cycle spent in state s, straight from the state table.
  function automatic obs_t expectFor(input int s, input logic [5:0] fn, input logic z,
                                     input logic rst, input logic ill, input logic [CW-1:0] ret);
    obs_t e;
    e = '0;
    e.state = 4'(s);
    e.retired = ret;
    case (s)
      0:  begin e.irwrite = 1; e.pcen = 1; e.alusrcb = 2'b01; e.aluop = 3'b010; end
      1:  begin e.alusrcb = 2'b11; e.aluop = 3'b010; e.illegal = ill; end
      2:  begin e.alusrca = 1; e.alusrcb = 2'b10; e.aluop = 3'b010; end
      3:  e.iord = 1;
      4:  begin e.memtoreg = 1; e.regwrite = 1; end
      5:  begin e.iord = 1; e.memwrite = 1; end
      6: begin
        e.alusrca = 1;
        case (fn)
          6'b100010: e.aluop = 3'b110;
          6'b100100: e.aluop = 3'b000;
          6'b100101: e.aluop = 3'b001;
          6'b101010: e.aluop = 3'b111;
          default:   e.aluop = 3'b010;
        endcase
      end
      7:  begin e.regdst = 1; e.regwrite = 1; end
      8:  begin e.alusrca = 1; e.aluop = 3'b110; e.pcsrc = 2'b01; e.pcen = z; end
      9:  begin e.alusrca = 1; e.alusrcb = 2'b10; e.aluop = 3'b010; end
      10: e.regwrite = 1;
      11: begin e.pcsrc = 2'b10; e.pcen = 1; end
      default: ;
    endcase
    if (rst) begin
      e.pcen = 0; e.memwrite = 0; e.irwrite = 0; e.regwrite = 0; e.illegal = 0;
    end
    return e;
  endfunction

  task automatic checkOutput(input obs_t exp, input obs_t got);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL cycle_outputs t=%0t state=%0d got=%h expected=%h", $time, exp.state, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (scoreActive) begin
      obs_t got;
      got = '{state, pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
              alusrca, alusrcb, pcsrc, aluop, illegal, retired};
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL scoreboard_empty t=%0t got_state=%0d expected=queued_entry", $time, state);
      end else begin
        checkOutput(sb.pop_front(), got);
      end
    end
  end

  // Hold reset for n cycles starting in model state s; the first cycle still shows s.
  task automatic holdReset(input int s, input int n);
    reset = 1'b1;
    for (int k = 0; k < n; k++) begin
      op = 6'($urandom); funct = 6'($urandom); zero = 1'($urandom);
      sb.push_back(expectFor((k == 0) ? s : 0, funct, zero, 1'b1, 1'b0,
                             (k == 0) ? retiredModel : '0));
      @(posedge clk); #1;
    end
    retiredModel = '0;
    reset = 1'b0;
  endtask

  // One instruction: op/funct are only meaningful in the states that sample them,
  // so garbage is driven everywhere else.
  task automatic applyStimulus(input logic [5:0] opIn, input logic [5:0] fnIn,
                               input int zsel, input int rstAt);
    int seq[$];
    case (opIn)
      6'b100011: seq = '{0, 1, 2, 3, 4};
      6'b101011: seq = '{0, 1, 2, 5};
      6'b000000: seq = '{0, 1, 6, 7};
      6'b000100: seq = '{0, 1, 8};
      6'b001000: seq = '{0, 1, 9, 10};
      6'b000010: seq = '{0, 1, 11};
      default:   seq = '{0, 1};
    endcase
    for (int i = 0; i < seq.size(); i++) begin
      int s;
      s = seq[i];
      if (i == rstAt) begin
        holdReset(s, 3);
        return;
      end
      op    = (s == 1 || s == 2 || s == 6) ? opIn : 6'($urandom);
      funct = (s == 6) ? fnIn : 6'($urandom);
      zero  = (zsel < 0) ? 1'($urandom) : 1'(zsel);
      sb.push_back(expectFor(s, funct, zero, 1'b0, (s == 1) && !legalOp(opIn), retiredModel));
      if (isTerminal(s))
        retiredModel = retiredModel + 1'b1;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic [5:0] opTab[6];
    logic [5:0] fnTab[5];
    opTab = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    fnTab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    reset = 1'b1; op = '0; funct = '0; zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    scoreActive = 1;
    holdReset(0, 1);

    applyStimulus(6'b100011, 6'b0, -1, -1);
    applyStimulus(6'b100011, 6'b0, -1, 3);
    applyStimulus(6'b000000, 6'b100010, -1, -1);
    applyStimulus(6'b000000, 6'b100101, -1, -1);
    applyStimulus(6'b000000, 6'b101010, -1, -1);
    applyStimulus(6'b000100, 6'b0, 1, -1);
    applyStimulus(6'b000100, 6'b0, 0, -1);
    holdReset(0, 1);
    applyStimulus(6'b101011, 6'b0, -1, -1);
    applyStimulus(6'b001000, 6'b0, -1, -1);
    applyStimulus(6'b000010, 6'b0, -1, -1);
    applyStimulus(6'b111111, 6'b0, -1, -1);
    applyStimulus(6'b000000, 6'b000000, -1, -1);

    for (int n = 0; n < 120; n++) begin
      logic [5:0] o;
      logic [5:0] f;
      int pick;
      pick = $urandom_range(0, 7);
      if (pick < 6) o = opTab[pick];
      else begin
        o = 6'($urandom);
        while (legalOp(o)) o = 6'($urandom);
      end
      f = ($urandom_range(0, 5) < 5) ? fnTab[$urandom_range(0, 4)] : 6'($urandom);
      applyStimulus(o, f, -1, ($urandom_range(0, 14) == 0) ? $urandom_range(0, 4) : -1);
    end

    scoreActive = 0;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboard_drain left=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
